// File: rtl/cte_pkg.sv
// Shared constants and types for the CTE RGB-to-YUV 4:2:2 stream encoder.
// Holds the Q.10 coefficients, a rescaling helper, and the pair/byte/pixel state enums.
package cte_pkg;

    localparam int COEF_FRAC = 10;

    localparam int CY_R = 306;
    localparam int CY_G = 601;
    localparam int CY_B = 117;
    localparam int CU_R = -173;
    localparam int CU_G = -339;
    localparam int CU_B = 512;
    localparam int CV_R = 512;
    localparam int CV_G = -429;
    localparam int CV_B = -83;

    typedef enum logic {
        P_EVEN,
        P_ODD
    } pair_st_t;

    typedef enum logic [1:0] {
        B_U,
        B_Y0,
        B_V,
        B_Y1
    } byte_ph_t;

    // Role of a pixel inside its pair, carried alongside it down the pipe.
    // K_SOLO is a frame-ending even pixel whose Y is replicated as Y1.
    typedef enum logic [1:0] {
        K_EVEN,
        K_ODD,
        K_SOLO
    } pix_kind_t;

    // Rescale a Q.10 coefficient to Q.frac, rounding half up when narrowing.
    function automatic int coef(input int c, input int frac);
        if (frac >= COEF_FRAC)
            return c * (2 ** (frac - COEF_FRAC));
        return (c + 2 ** (COEF_FRAC - frac - 1)) >>> (COEF_FRAC - frac);
    endfunction

    // Signed width that holds any coefficient sum with headroom.
    function automatic int sum_w(input int dw, input int frac);
        return dw + frac + 3;
    endfunction

endpackage

// File: rtl/cte_rgb2yuv_core.sv
// Two-stage per-pixel RGB-to-YUV pipe: stage 1 multiply-accumulate, stage 2 round/clip.
// Ports: clk, reset (async active-low), in_valid/rgb/kind_in/last_in in,
//        out_valid/kind_out/last_out, y (clipped), u/v (rounded, unclipped) out.
module cte_rgb2yuv_core
    import cte_pkg::*;
#(
    parameter int DW   = 8,
    parameter int FRAC = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [3*DW-1:0]               rgb,
    input  pix_kind_t                     kind_in,
    input  logic                          last_in,
    output logic                          out_valid,
    output pix_kind_t                     kind_out,
    output logic                          last_out,
    output logic [DW-1:0]                 y,
    output logic signed [sum_w(DW,FRAC)-1:0] u,
    output logic signed [sum_w(DW,FRAC)-1:0] v
);

    localparam int SW = sum_w(DW, FRAC);
    typedef logic signed [SW-1:0] s_t;

    localparam s_t KYR = s_t'(coef(CY_R, FRAC));
    localparam s_t KYG = s_t'(coef(CY_G, FRAC));
    localparam s_t KYB = s_t'(coef(CY_B, FRAC));
    localparam s_t KUR = s_t'(coef(CU_R, FRAC));
    localparam s_t KUG = s_t'(coef(CU_G, FRAC));
    localparam s_t KUB = s_t'(coef(CU_B, FRAC));
    localparam s_t KVR = s_t'(coef(CV_R, FRAC));
    localparam s_t KVG = s_t'(coef(CV_G, FRAC));
    localparam s_t KVB = s_t'(coef(CV_B, FRAC));
    localparam s_t HALF = s_t'(2 ** (FRAC - 1));
    localparam s_t YMAX = s_t'(2 ** DW - 1);

    s_t r, g, b;
    assign r = s_t'(rgb[3*DW-1 -: DW]);
    assign g = s_t'(rgb[2*DW-1 -: DW]);
    assign b = s_t'(rgb[DW-1:0]);

    logic      v1;
    pix_kind_t k1;
    logic      l1;
    s_t        sy, su, sv;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1 <= 1'b0;
            k1 <= K_EVEN;
            l1 <= 1'b0;
            sy <= '0;
            su <= '0;
            sv <= '0;
        end else begin
            v1 <= in_valid;
            k1 <= kind_in;
            l1 <= last_in;
            sy <= KYR * r + KYG * g + KYB * b;
            su <= KUR * r + KUG * g + KUB * b;
            sv <= KVR * r + KVG * g + KVB * b;
        end
    end

    s_t ry, ru, rv;
    assign ry = (sy + HALF) >>> FRAC;
    assign ru = (su + HALF) >>> FRAC;
    assign rv = (sv + HALF) >>> FRAC;

    // U/V stay unclipped so the pairing stage can average before clipping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            kind_out  <= K_EVEN;
            last_out  <= 1'b0;
            y         <= '0;
            u         <= '0;
            v         <= '0;
        end else begin
            out_valid <= v1;
            kind_out  <= k1;
            last_out  <= l1;
            if (ry < 0)
                y <= '0;
            else if (ry > YMAX)
                y <= YMAX[DW-1:0];
            else
                y <= ry[DW-1:0];
            u <= ru;
            v <= rv;
        end
    end

endmodule

// File: rtl/cte_yuv422_stream.sv
// RGB-to-YUV 4:2:2 stream encoder: pairing FSM, credit counter, pair FIFO, byte serializer.
// Ports: clk, reset (async active-low), in_valid/in_ready/rgb_in/in_last,
//        out_valid/out_ready/yuv_out/out_last. Macro CTE_CHROMA_AVG_EN averages pair chroma.
module cte_yuv422_stream
    import cte_pkg::*;
#(
    parameter int DW         = 8,
    parameter int FRAC       = 10,
    parameter int PAIR_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3*DW-1:0] rgb_in,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   yuv_out,
    output logic            out_last
);

    localparam int SW = sum_w(DW, FRAC);
    localparam int PW = (PAIR_DEPTH > 1) ? $clog2(PAIR_DEPTH) : 1;
    localparam int CW = $clog2(PAIR_DEPTH + 1);
    localparam int EW = 4 * DW + 1;

    typedef logic signed [SW-1:0] s_t;

    localparam s_t SMIN = s_t'(-(2 ** (DW - 1)));
    localparam s_t SMAX = s_t'(2 ** (DW - 1) - 1);

    function automatic logic [DW-1:0] clip_s(input s_t x);
        if (x < SMIN)
            return SMIN[DW-1:0];
        if (x > SMAX)
            return SMAX[DW-1:0];
        return x[DW-1:0];
    endfunction

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(PAIR_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    pair_st_t        state, state_nx;
    logic            run;
    logic [CW-1:0]   fifo_cnt, open_cnt;
    logic [CW:0]     used;
    logic            accept, open_inc;
    logic            push, pop;
    pix_kind_t       acc_kind;

    assign used     = {1'b0, fifo_cnt} + {1'b0, open_cnt};
    assign in_ready = run & ((state == P_ODD) |
                      (used < (CW+1)'(PAIR_DEPTH)));
    assign accept   = in_valid & in_ready;
    assign open_inc = accept & (state == P_EVEN);
    assign acc_kind = (state == P_ODD) ? K_ODD :
                      (in_last ? K_SOLO : K_EVEN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= P_EVEN;
            run   <= 1'b0;
        end else begin
            state <= state_nx;
            run   <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        if (accept) begin
            unique case (state)
                P_EVEN: if (!in_last) state_nx = P_ODD;
                P_ODD:  state_nx = P_EVEN;
            endcase
        end
    end

    logic            pix_valid, pix_last;
    pix_kind_t       pix_kind;
    logic [DW-1:0]   pix_y;
    s_t              pix_u, pix_v;

    cte_rgb2yuv_core #(
        .DW   (DW),
        .FRAC (FRAC)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (accept),
        .rgb       (rgb_in),
        .kind_in   (acc_kind),
        .last_in   (in_last),
        .out_valid (pix_valid),
        .kind_out  (pix_kind),
        .last_out  (pix_last),
        .y         (pix_y),
        .u         (pix_u),
        .v         (pix_v)
    );

    logic [DW-1:0] e_y;
    s_t            e_u, e_v;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_y <= '0;
            e_u <= '0;
            e_v <= '0;
        end else if (pix_valid && pix_kind == K_EVEN) begin
            e_y <= pix_y;
            e_u <= pix_u;
            e_v <= pix_v;
        end
    end

    // Word layout: {last, U, Y0, V, Y1}. A solo pixel's chroma already
    // equals the average of itself with itself.
    logic [EW-1:0] word_c, push_word;
    logic          pair_done;

    assign pair_done = pix_valid & (pix_kind != K_EVEN);

    always_comb begin
        word_c = {1'b1, clip_s(pix_u), pix_y, clip_s(pix_v), pix_y};
        if (pix_kind == K_ODD) begin
`ifdef CTE_CHROMA_AVG_EN
            word_c = {pix_last,
                      clip_s((e_u + pix_u + s_t'(1)) >>> 1), e_y,
                      clip_s((e_v + pix_v + s_t'(1)) >>> 1), pix_y};
`else
            word_c = {pix_last, clip_s(e_u), e_y, clip_s(e_v), pix_y};
`endif
        end
    end

`ifdef CTE_CHROMA_AVG_EN
    logic          pend_valid;
    logic [EW-1:0] pend_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_valid <= 1'b0;
            pend_word  <= '0;
        end else begin
            pend_valid <= pair_done;
            pend_word  <= word_c;
        end
    end

    assign push      = pend_valid;
    assign push_word = pend_word;
`else
    assign push      = pair_done;
    assign push_word = word_c;
`endif

    logic [EW-1:0] mem [PAIR_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [EW-1:0] head;
    byte_ph_t      ph;

    assign head      = mem[rd_ptr];
    assign out_valid = (fifo_cnt != '0);
    assign pop       = out_valid & out_ready & (ph == B_Y1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PAIR_DEPTH; i++)
                mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            open_cnt <= '0;
            ph       <= B_U;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop)
                rd_ptr <= nxt(rd_ptr);
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            unique case ({open_inc, push})
                2'b10:   open_cnt <= open_cnt + CW'(1);
                2'b01:   open_cnt <= open_cnt - CW'(1);
                default: open_cnt <= open_cnt;
            endcase
            if (out_valid && out_ready)
                ph <= byte_ph_t'(ph + 2'd1);
        end
    end

    logic [DW-1:0] byte_sel;

    always_comb begin
        byte_sel = '0;
        unique case (ph)
            B_U:  byte_sel = head[4*DW-1 -: DW];
            B_Y0: byte_sel = head[3*DW-1 -: DW];
            B_V:  byte_sel = head[2*DW-1 -: DW];
            B_Y1: byte_sel = head[DW-1:0];
        endcase
    end

    assign yuv_out  = out_valid ? byte_sel : '0;
    assign out_last = out_valid & (ph == B_Y1) & head[EW-1];

    // Credits reserve FIFO space at pair open, so a full push is a bug.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (!reset)
        !(push && fifo_cnt == CW'(PAIR_DEPTH)));

endmodule

// File: tb/tb_cte_yuv422_stream.sv
// Self-checking bench for cte_yuv422_stream with directed cases and random traffic.
// A frame-level model turns every accepted pixel into expected output bytes.
module tb_cte_yuv422_stream;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [23:0] rgb_in = '0;
    logic        in_ready, out_valid, out_last;
    logic [7:0]  yuv_out;

    cte_yuv422_stream #(
        .DW         (8),
        .FRAC       (10),
        .PAIR_DEPTH (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rgb_in    (rgb_in),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .yuv_out   (yuv_out),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_acc = 0;
    bit         last_acc = 0;
    bit         have_even = 0;
    int         ey, eu, ev;
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic int rnd(input int x);
        return (x + 512) >>> 10;
    endfunction

    function automatic int clip_y(input int x);
        return (x < 0) ? 0 : ((x > 255) ? 255 : x);
    endfunction

    function automatic int clip_c(input int x);
        return (x < -128) ? -128 : ((x > 127) ? 127 : x);
    endfunction

    function automatic void emit(input int u, input int y0, input int v,
                                 input int y1, input logic l);
        exp_q.push_back({1'b0, 8'(u)});
        exp_q.push_back({1'b0, 8'(y0)});
        exp_q.push_back({1'b0, 8'(v)});
        exp_q.push_back({l, 8'(y1)});
    endfunction

    function automatic void model_accept(input logic [23:0] p, input logic l);
        int r, g, b, y, u, v, uu, vv;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        y = clip_y(rnd(306 * r + 601 * g + 117 * b));
        u = rnd(-173 * r - 339 * g + 512 * b);
        v = rnd(512 * r - 429 * g - 83 * b);
        if (!have_even) begin
            if (l) begin
                emit(clip_c(u), y, clip_c(v), y, 1'b1);
            end else begin
                ey = y;
                eu = u;
                ev = v;
                have_even = 1;
            end
        end else begin
`ifdef CTE_CHROMA_AVG_EN
            uu = clip_c((eu + u + 1) >>> 1);
            vv = clip_c((ev + v + 1) >>> 1);
`else
            uu = clip_c(eu);
            vv = clip_c(ev);
`endif
            emit(uu, ey, vv, y, l);
            have_even = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            have_even = 0;
            last_acc = 0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0)
                    chk("out_valid_idle", 32'(out_valid), 0);
                else
                    chk("byte", {23'd0, out_last, yuv_out}, 32'(exp_q[0]));
                if (out_ready) begin
                    got_q.push_back({out_last, yuv_out});
                    if (exp_q.size() != 0)
                        void'(exp_q.pop_front());
                end
            end
            last_acc = in_valid && in_ready;
            if (last_acc) begin
                model_accept(rgb_in, in_last);
                n_acc++;
            end
        end
    end

    task automatic send(input logic [23:0] p, input logic l);
        bit ok;
        int t;
        ok = 0;
        t = 0;
        in_valid = 1'b1;
        rgb_in = p;
        in_last = l;
        while (!ok && t < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!ok)
            chk("send_timeout", 32'(in_ready), 1);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_valid", 32'(out_valid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, base, t;
        logic [23:0] pa, pb;
        logic [8:0]  want2 [4];
        #12;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_yuv_out", 32'(yuv_out), 0);
        chk("rst_out_last", 32'(out_last), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", 32'(in_ready), 1);

        // White pair: latency and values
        out_ready = 1'b1;
        got_q.delete();
        send(24'hFFFFFF, 1'b0);
        send(24'hFFFFFF, 1'b0);
        k = 2;
        while (!out_valid && k < 30) begin
            @(posedge clk);
            #1;
            k++;
        end
`ifdef CTE_CHROMA_AVG_EN
        chk("t1_latency", k, 5);
`else
        chk("t1_latency", k, 4);
`endif
        drain();
        chk("t1_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            chk("t1_u", 32'(got_q[0]), 9'h000);
            chk("t1_y0", 32'(got_q[1]), 9'h0FF);
            chk("t1_v", 32'(got_q[2]), 9'h000);
            chk("t1_y1", 32'(got_q[3]), 9'h0FF);
        end

        // Red then green (blue when averaging): clipping / averaging
        got_q.delete();
        pa = 24'hFF0000;
`ifdef CTE_CHROMA_AVG_EN
        pb = 24'h0000FF;
        want2 = '{9'h02B, 9'h04C, 9'h036, 9'h01D};
`else
        pb = 24'h00FF00;
        want2 = '{9'h0D5, 9'h04C, 9'h07F, 9'h096};
`endif
        send(pa, 1'b0);
        send(pb, 1'b0);
        drain();
        chk("t2_count", got_q.size(), 4);
        if (got_q.size() == 4)
            for (int i = 0; i < 4; i++)
                chk("t2_byte", 32'(got_q[i]), 32'(want2[i]));

        // Odd-length frame: replicated last pixel
        got_q.delete();
        send(24'h000000, 1'b0);
        send(24'h000000, 1'b0);
        send(24'h000000, 1'b1);
        drain();
        chk("t3_count", got_q.size(), 8);
        if (got_q.size() == 8)
            for (int i = 0; i < 8; i++)
                chk("t3_byte", 32'(got_q[i]), (i == 7) ? 32'h100 : 32'h000);

        // Output stall: credits bound accepts
        out_ready = 1'b0;
        base = n_acc;
        in_valid = 1'b1;
        in_last = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rgb_in = 24'($urandom);
            @(posedge clk);
            #1;
        end
        chk("t4_accepts", n_acc - base, 4);
        chk("t4_in_ready", 32'(in_ready), 0);
        in_valid = 1'b0;
        drain();

        // Reset after an even pixel with a pair waiting in the FIFO
        out_ready = 1'b0;
        send(24'h123456, 1'b0);
        send(24'h654321, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_pre_valid", 32'(out_valid), 1);
        send(24'hABCDEF, 1'b0);
        reset = 1'b0;
        #1;
        chk("t5_out_valid", 32'(out_valid), 0);
        chk("t5_in_ready", 32'(in_ready), 0);
        chk("t5_yuv_out", 32'(yuv_out), 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        got_q.delete();
        out_ready = 1'b1;
        send(24'hFFFFFF, 1'b0);
        send(24'hFFFFFF, 1'b0);
        drain();
        chk("t5_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            chk("t5_u", 32'(got_q[0]), 9'h000);
            chk("t5_y0", 32'(got_q[1]), 9'h0FF);
            chk("t5_v", 32'(got_q[2]), 9'h000);
            chk("t5_y1", 32'(got_q[3]), 9'h0FF);
        end

        // Random traffic with random backpressure
        base = n_acc;
        t = 0;
        in_valid = 1'b0;
        while (n_acc - base < 500 && t < 20000) begin
            @(posedge clk);
            #1;
            t++;
            out_ready = ($urandom_range(0, 9) < 6);
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 9) < 7);
                rgb_in = 24'($urandom);
                in_last = ($urandom_range(0, 15) == 0);
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        chk("rand_budget", 32'(t < 20000), 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
